// File: rtl/bitty_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
//   Shared definitions for the bitty instruction-fetch path.
//   - Default instruction / address widths
//   - Fetch FSM state encoding
//   - FIFO entry layout {pc, instr} at the default widths
// -----------------------------------------------------------------------------
package bitty_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_ADDR_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
//   Parametrised synchronous FIFO holding prefetched instruction entries.
//   Head data is combinational from storage (valid only while !empty).
//
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   push   in   write wdata (ignored when full unless popping in the same cycle)
//   pop    in   remove head (ignored when empty)
//   flush  in   empty the FIFO; wins over push/pop
//   wdata  in   WIDTH  entry to write
//   rdata  out  WIDTH  head entry
//   count  out  occupancy 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module prefetch_fifo
    import bitty_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + DEF_INSTR_W,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // Push into a full FIFO is allowed only when a pop frees the slot this cycle.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
//   Fetches sequential instruction words from a request/response memory into a
//   DEPTH-entry prefetch FIFO and presents the FIFO head to the core.
//   A redirect flushes the FIFO, drops any in-flight response and restarts
//   fetch at redirect_pc.
//
//   Optional build macro INSTR_PREFETCH_PERF_EN adds stall_cycles/flush_count.
//
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   mem_req      out  memory request, held until mem_valid
//   mem_addr     out  ADDR_W  word address of the request
//   mem_valid    in   response strobe (meaningful while mem_req)
//   mem_rdata    in   INSTR_W response data
//   done         in   core consumed head instruction (pop)
//   instr        out  INSTR_W head instruction, 0 when empty
//   instr_pc     out  ADDR_W  head address, 0 when empty
//   instr_valid  out  FIFO non-empty
//   redirect     in   flush and restart fetch
//   redirect_pc  in   ADDR_W  new fetch address
//   stall_cycles out  32  (perf build) cycles with no valid instruction
//   flush_count  out  16  (perf build) number of redirects
// -----------------------------------------------------------------------------
module instr_prefetch_unit
    import bitty_pkg::*;
#(
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               done,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef INSTR_PREFETCH_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    fetch_state_e        state, state_n;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0]   held_addr;
    logic                push, pop;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   head_pc;
    logic [INSTR_W-1:0]  head_instr;
    logic [CNT_W-1:0]    count;
    logic                full, empty;
    logic [CNT_W:0]      cnt_after;

    prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({fetch_pc, mem_rdata}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign {head_pc, head_instr} = head;
    assign instr_valid = ~empty;
    assign instr       = empty ? '0 : head_instr;
    assign instr_pc    = empty ? '0 : head_pc;

    // Redirect flushes the FIFO, so a same-cycle done must not pop.
    assign pop = done & ~empty & ~redirect;

    // Occupancy after this cycle's push and pop; with no other request
    // outstanding, another request is allowed while this stays below DEPTH.
    assign cnt_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            held_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            // Keep presenting the abandoned address until its response drains.
            if (state == REQ && redirect && !mem_valid)
                held_addr <= fetch_pc;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = fetch_pc;
        unique case (state)
            IDLE: begin
                if (redirect || !full) state_n = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (redirect) begin
                    // A response landing with the redirect completes the
                    // handshake and is simply dropped.
                    state_n = mem_valid ? REQ : DISCARD;
                end else if (mem_valid) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 1'b1;
                    state_n    = (cnt_after < (CNT_W+1)'(DEPTH)) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = held_addr;
                // Once the stale response arrives the handshake is over, so
                // even a redirect in this cycle can restart fetch directly.
                if (mem_valid) state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
        if (redirect) fetch_pc_n = redirect_pc;
    end

`ifdef INSTR_PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!instr_valid && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit (default parameters).
// Memory model: returns {8'hA0, addr} after `lat` wait cycles of a held request.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        done;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        redirect;
    logic [7:0]  redirect_pc;
`ifdef INSTR_PREFETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [15:0] fc_before;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int wcnt  = 0;
    int acc_cnt = 0;
    logic force_valid = 1'b0;

    instr_prefetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .done        (done),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef INSTR_PREFETCH_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    assign mem_valid = force_valid | (mem_req && (wcnt >= lat));
    assign mem_rdata = {8'hA0, mem_addr};

    always @(posedge clk) begin
        if (!mem_req || mem_valid) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (reset && mem_req && mem_valid) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; done = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        force_valid = 1'b1;

        // Reset held for 3 cycles with a spurious response strobe.
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_instr",   32'(instr), 32'd0);
        chk("rst_pc",      32'(instr_pc), 32'd0);
        chk("rst_addr",    32'(mem_addr), 32'd0);

        // Fill with core stalled, zero-wait memory.
        force_valid = 1'b0; lat = 0; reset = 1'b1;
        tick();
        chk("first_req",  32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd0);
        repeat (4) tick();
        chk("fill_req_off", 32'(mem_req), 32'd0);
        chk("fill_valid",   32'(instr_valid), 32'd1);
        chk("fill_pc",      32'(instr_pc), 32'd0);
        chk("fill_instr",   32'(instr), 32'hA000);
        chk("fill_acc",     32'(acc_cnt), 32'd4);
        repeat (2) tick();
        chk("full_hold_req", 32'(mem_req), 32'd0);
        chk("full_hold_acc", 32'(acc_cnt), 32'd4);

        // In-order drain, done every cycle: no gaps.
        done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("drain_valid", 32'(instr_valid), 32'd1);
            chk("drain_instr", 32'(instr), 32'(16'hA000 + 16'(i)));
        end

        // Redirect to 5 (response in the same cycle is dropped), then a slow memory.
        done = 1'b0; redirect = 1'b1; redirect_pc = 8'h05;
        tick();
        redirect = 1'b0; lat = 2;
        chk("rd5_valid", 32'(instr_valid), 32'd0);
        chk("rd5_addr",  32'(mem_addr), 32'h05);
        tick();
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("disc_req",   32'(mem_req), 32'd1);
        chk("disc_addr",  32'(mem_addr), 32'h05);
        chk("disc_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("post_disc_addr",  32'(mem_addr), 32'h40);
        chk("post_disc_valid", 32'(instr_valid), 32'd0);
        tick();
        tick();
        chk("r40_valid_early", 32'(instr_valid), 32'd0);
        tick();
        chk("r40_valid", 32'(instr_valid), 32'd1);
        chk("r40_pc",    32'(instr_pc), 32'h40);
        chk("r40_instr", 32'(instr), 32'hA040);

        // Wrap-around from FE.
        lat = 0; redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        chk("wrap_addr0",  32'(mem_addr), 32'hFE);
        chk("wrap_valid0", 32'(instr_valid), 32'd0);
        tick();
        chk("wrap_addr1", 32'(mem_addr), 32'hFF);
        chk("wrap_pc1",   32'(instr_pc), 32'hFE);
        tick();
        chk("wrap_addr2", 32'(mem_addr), 32'h00);
        tick();
        chk("wrap_addr3", 32'(mem_addr), 32'h01);
        tick();
        chk("wrap_full_req", 32'(mem_req), 32'd0);
        chk("wrap_head",     32'(instr), 32'hA0FE);
        done = 1'b1;
        tick();
        chk("wrap_pop_ff", 32'(instr_pc), 32'hFF);
        tick();
        chk("wrap_pop_00", 32'(instr_pc), 32'h00);
        tick();
        chk("wrap_pop_01", 32'(instr_pc), 32'h01);

        // Bring FIFO to 3 entries, then redirect + done + mem_valid together.
        done = 1'b0;
        tick();
        chk("pre3_valid", 32'(mem_valid), 32'd1);
        chk("pre3_head",  32'(instr_pc), 32'h01);
`ifdef INSTR_PREFETCH_PERF_EN
        fc_before = flush_count;
`endif
        redirect = 1'b1; redirect_pc = 8'h80; done = 1'b1;
        tick();
        redirect = 1'b0;
        chk("same_valid", 32'(instr_valid), 32'd0);
        chk("same_instr", 32'(instr), 32'd0);
        chk("same_pc",    32'(instr_pc), 32'd0);
        chk("same_addr",  32'(mem_addr), 32'h80);
        chk("same_req",   32'(mem_req), 32'd1);
`ifdef INSTR_PREFETCH_PERF_EN
        chk("flush_cnt", 32'(flush_count), 32'(fc_before + 16'd1));
`endif
        // done stays high while empty: must not disturb the incoming push.
        tick();
        chk("after_valid", 32'(instr_valid), 32'd1);
        chk("after_pc",    32'(instr_pc), 32'h80);
        chk("after_instr", 32'(instr), 32'hA080);
        done = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
Parametrised successor to the single-word instruction fetch unit. It fetches sequential instruction words from a request/response instruction memory into a DEPTH-entry prefetch FIFO, and presents the FIFO head to bitty_core with a valid flag. Each core `done` pulse pops one entry. A redirect input (branch/jump) flushes the FIFO, discards any in-flight response and restarts fetch at a new PC.

Parameters:
- INSTR_W, 16, instruction word width in bits
- ADDR_W, 8, word-address width; PC wraps modulo 2^ADDR_W
- DEPTH, 4, prefetch FIFO entries; power of two, >=2
- RESET_PC, 0, fetch address loaded at reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- mem_req  output  1  memory request; held high until accepted
- mem_addr  output  ADDR_W  word address of the current request
- mem_valid  input  1  response strobe; only meaningful while mem_req=1
- mem_rdata  input  INSTR_W  response data, sampled when mem_req&mem_valid
- done  input  1  core has consumed the current instr (pop)
- instr  output  INSTR_W  FIFO head instruction; 0 when empty
- instr_pc  output  ADDR_W  address of the FIFO head; 0 when empty
- instr_valid  output  1  FIFO non-empty
- redirect  input  1  flush and restart fetch
- redirect_pc  input  ADDR_W  new fetch address, sampled with redirect

Behaviour:
- Reset (reset=0 at a clk edge):
  - fetch_pc=RESET_PC, FIFO empty, FSM=IDLE.
  - mem_req=0, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
  - Reset mid-request abandons the request. Memory must tolerate mem_req dropping.
- FIFO:
  - Stores {pc, instr}.
  - Head outputs are combinational from the storage registers.
  - count ranges 0..DEPTH.
- Credit rule: a new request may issue only when count + outstanding < DEPTH, so a response always has a free slot.
- FSM states:
  - IDLE: if credit available, go to REQ next cycle (mem_req=1, mem_addr=fetch_pc).
  - REQ: mem_req=1, mem_addr stable.
    - On mem_valid: push {fetch_pc, mem_rdata} and fetch_pc+=1 (wraps 2^ADDR_W-1 -> 0).
    - Then stay in REQ if credit remains after the push, else go to IDLE. Back-to-back fetch gives 1 word/cycle with a zero-wait memory.
  - DISCARD: entered on redirect while in REQ without mem_valid in the same cycle.
    - mem_req stays high and mem_addr is held at the old address until mem_valid.
    - That response is dropped; then go to REQ at the new fetch_pc.
- Pop: done & instr_valid removes the head. done while empty is ignored.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. This is legal even when full, since the credit rule prevents a push at count=DEPTH anyway.
  - Redirect has priority over done and over push:
    - FIFO flushed (count=0) and fetch_pc=redirect_pc on the next edge.
    - A mem_valid arriving in the same cycle as redirect is dropped and the FSM goes to REQ (no DISCARD needed).
    - Redirect in IDLE goes to REQ.
  - Redirect during DISCARD: fetch_pc is updated, state stays DISCARD.
- Latency:
  - Redirect at edge N: the first request at redirect_pc is visible after edge N (when no discard is needed).
  - The instruction is visible one cycle after the accepting mem_valid edge.

Optional Feature:
- Macro: INSTR_PREFETCH_PERF_EN.
- When defined, adds output ports:
  - stall_cycles (32 bits): increments every cycle with instr_valid=0 and reset high.
  - flush_count (16 bits): increments on each redirect.
  - Both saturate at all-ones and clear on reset.
- When undefined, these ports and their counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package bitty_pkg holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, DISCARD=2'd2.
  - Default INSTR_W and ADDR_W constants.
  - A typedef for the FIFO entry {pc, instr}.
- One sub-module is natural: prefetch_fifo, a parametrised sync FIFO (width, depth) with push, pop, flush, count, full and empty.
- The fetch FSM and credit logic stay in instr_prefetch_unit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with mem_valid=1 -> mem_req=0, instr_valid=0, instr=0. After release, first mem_addr=RESET_PC.
- Fill while core stalled: zero-wait memory, done=0 -> exactly 4 responses accepted (addrs 0..3), then mem_req=0, instr_valid=1, instr_pc=0.
- In-order drain: memory returns data=addr+16'hA000, done=1 every cycle -> instr sequence A000, A001, A002… with no gaps after the first fill.
- Redirect mid-request: 3-cycle memory; redirect to 8'h40 one cycle after a request to addr 5 -> FSM enters DISCARD, addr 5 data never appears, next instr_pc=8'h40.
- Wrap-around: redirect_pc=8'hFE -> fetch addresses FE, FF, 00, 01, and instr_pc follows.
- Same-cycle redirect+done+mem_valid with FIFO at 3 -> FIFO empty next cycle, response dropped, mem_addr=redirect_pc. With INSTR_PREFETCH_PERF_EN, flush_count increments by 1.
